scan_master: RTL and testbench

SCAN_MASTER -- requirements
Module: scan_master

---
 rtl/scan_master.sv | 265 ++++++++++++++++++++++++++
 tb/tb_scan_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_master.sv
// -----------------------------------------------------------------------------
// scan_master
//
// Drives a chip scan chain through one transaction:
//   optional CAPTURE bit period -> N SHIFT bit periods -> UPDATE strobe -> DONE.
// Each bit period is S0 (1 cycle, new scan_in) / S1 (H cycles, phi) /
// S2 (1 cycle gap) / S3 (H cycles, phi_bar), so the two shift phases never
// overlap.
//
// Optional feature macro: SCAN_MASTER_READBACK_EN
//   defined   : CAPTURE period and read_data sampling of scan_out are built in.
//   undefined : capture and read_data are tied low and scan_out is ignored.
//
// Every output is a flop. Each output flop is loaded from the next-state
// decode, so it lines up cycle-for-cycle with the FSM state it represents.
// -----------------------------------------------------------------------------
module scan_master #(
    parameter int REGISTER_LENGTH = 30,
    parameter int HALF_CYCLES     = 2
) (
    input  logic                       ref_clk,
    input  logic                       reset_bar,
    input  logic                       start,
    input  logic [REGISTER_LENGTH-1:0] write_data,
    output logic                       busy,
    output logic                       done,
    output logic [REGISTER_LENGTH-1:0] read_data,
    output logic                       scan_in,
    output logic                       phi,
    output logic                       phi_bar,
    output logic                       capture,
    output logic                       update,
    input  logic                       scan_out
);

    localparam int N     = REGISTER_LENGTH;
    localparam int BIT_W = $clog2(N) + 1;

    // Terminal counts: last S1/S3/UPDATE hold cycle and index of the last bit.
    localparam logic [3:0]       LAST_HOLD = 4'(HALF_CYCLES - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(N - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT,
        ST_UPDATE,
        ST_DONE
    } state_e;

    // Position inside a bit period. UPDATE reuses S1 (strobe) and S2 (gap).
    typedef enum logic [1:0] {
        PH_S0,
        PH_S1,
        PH_S2,
        PH_S3
    } phase_e;

`ifdef SCAN_MASTER_READBACK_EN
    localparam state_e FIRST_STATE = ST_CAPTURE;
`else
    localparam state_e FIRST_STATE = ST_SHIFT;
`endif

    state_e             state_q, state_d;
    phase_e             phase_q, phase_d;
    logic [3:0]         hold_q,  hold_d;
    logic [BIT_W-1:0]   bit_q,   bit_d;
    logic [N-1:0]       sr_q,    sr_d;

    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               scan_in_q, scan_in_d;
    logic               phi_q,     phi_d;
    logic               phi_bar_q, phi_bar_d;
    logic               update_q,  update_d;

    // Next-state sequencing: state, phase, hold/bit counters and outgoing data.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch instead of logic.
        state_d   = state_q;
        phase_d   = phase_q;
        hold_d    = hold_q;
        bit_d     = bit_q;
        sr_d      = sr_q;
        scan_in_d = scan_in_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = FIRST_STATE;
                    phase_d = PH_S0;
                    hold_d  = '0;
                    bit_d   = '0;
`ifdef SCAN_MASTER_READBACK_EN
                    // Capture period drives a quiet 0 into the chain.
                    sr_d      = write_data;
                    scan_in_d = 1'b0;
`else
                    // Straight into bit 0: present the MSB now.
                    sr_d      = {write_data[N-2:0], 1'b0};
                    scan_in_d = write_data[N-1];
`endif
                end
            end

            ST_CAPTURE, ST_SHIFT: begin
                case (phase_q)
                    PH_S0: begin
                        phase_d = PH_S1;
                        hold_d  = '0;
                    end
                    PH_S1: begin
                        if (hold_q == LAST_HOLD) begin
                            phase_d = PH_S2;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + 4'd1;
                        end
                    end
                    PH_S2: begin
                        phase_d = PH_S3;
                        hold_d  = '0;
                    end
                    PH_S3: begin
                        if (hold_q != LAST_HOLD) begin
                            hold_d = hold_q + 4'd1;
                        end else if (state_q == ST_SHIFT && bit_q == LAST_BIT) begin
                            // Last bit shifted: strobe the update latch.
                            state_d = ST_UPDATE;
                            phase_d = PH_S1;
                            hold_d  = '0;
                        end else begin
                            // Next bit period; scan_in only ever moves here.
                            if (state_q == ST_SHIFT) begin
                                bit_d = bit_q + 1'b1;
                            end
                            state_d   = ST_SHIFT;
                            phase_d   = PH_S0;
                            hold_d    = '0;
                            scan_in_d = sr_q[N-1];
                            sr_d      = {sr_q[N-2:0], 1'b0};
                        end
                    end
                    default: phase_d = PH_S0;
                endcase
            end

            ST_UPDATE: begin
                if (phase_q == PH_S1) begin
                    if (hold_q == LAST_HOLD) begin
                        phase_d = PH_S2;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 4'd1;
                    end
                end else begin
                    // Single gap cycle after the strobe.
                    state_d = ST_DONE;
                    phase_d = PH_S0;
                    hold_d  = '0;
                end
            end

            ST_DONE: begin
                // start is deliberately not looked at here.
                state_d = ST_IDLE;
                phase_d = PH_S0;
            end

            default: begin
                state_d = ST_IDLE;
                phase_d = PH_S0;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs track it.
    always_comb begin
        busy_d    = (state_d == ST_CAPTURE) || (state_d == ST_SHIFT) ||
                    (state_d == ST_UPDATE);
        done_d    = (state_d == ST_DONE);
        phi_d     = ((state_d == ST_CAPTURE) || (state_d == ST_SHIFT)) &&
                    (phase_d == PH_S1);
        phi_bar_d = ((state_d == ST_CAPTURE) || (state_d == ST_SHIFT)) &&
                    (phase_d == PH_S3);
        update_d  = (state_d == ST_UPDATE) && (phase_d == PH_S1);
    end

    // State, counters, shift register and output flops.
    always_ff @(posedge ref_clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state_q   <= ST_IDLE;
            phase_q   <= PH_S0;
            hold_q    <= '0;
            bit_q     <= '0;
            // NOTE: the shift register is an ordinary flop bank, not a memory,
            // so it is cleared with everything else.
            sr_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scan_in_q <= 1'b0;
            phi_q     <= 1'b0;
            phi_bar_q <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop.
            state_q   <= state_d;
            phase_q   <= phase_d;
            hold_q    <= hold_d;
            bit_q     <= bit_d;
            sr_q      <= sr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            scan_in_q <= scan_in_d;
            phi_q     <= phi_d;
            phi_bar_q <= phi_bar_d;
            update_q  <= update_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign scan_in = scan_in_q;
    assign phi     = phi_q;
    assign phi_bar = phi_bar_q;
    assign update  = update_q;

`ifdef SCAN_MASTER_READBACK_EN
    logic         capture_q,   capture_d;
    logic [N-1:0] read_data_q, read_data_d;

    // Capture enable and MSB-first collection of scan_out at the end of S0.
    always_comb begin
        capture_d   = (state_d == ST_CAPTURE);
        read_data_d = read_data_q;
        if (state_q == ST_SHIFT && phase_q == PH_S0) begin
            read_data_d = {read_data_q[N-2:0], scan_out};
        end
    end

    // Readback flops; read_data holds from DONE until the next transaction.
    always_ff @(posedge ref_clk or negedge reset_bar) begin
        if (!reset_bar) begin
            capture_q   <= 1'b0;
            read_data_q <= '0;
        end else begin
            capture_q   <= capture_d;
            read_data_q <= read_data_d;
        end
    end

    assign capture   = capture_q;
    assign read_data = read_data_q;
`else
    // Readback not built: chain return data is not used.
    logic unused_scan_out;
    assign unused_scan_out = scan_out;
    assign capture         = 1'b0;
    assign read_data       = '0;
`endif

endmodule

// File: tb/tb_scan_master.sv
// -----------------------------------------------------------------------------
// tb_scan_master
//
// Two instances: a small one (N=4, H=1) and a default one (N=30, H=2), each
// hooked to a behavioural two-phase master/slave scan chain with parallel
// capture and an update latch. Expected values follow the build's
// SCAN_MASTER_READBACK_EN setting.
// -----------------------------------------------------------------------------
module tb_scan_master;

`ifdef SCAN_MASTER_READBACK_EN
    localparam int C = 1;
`else
    localparam int C = 0;
`endif

    localparam int T_S = (4 + C) * (2 * 1 + 2) + 1 + 1;
    localparam int T_L = (30 + C) * (2 * 2 + 2) + 2 + 1;

    localparam logic [3:0]  PAR_S = 4'b0110;
    localparam logic [29:0] PAR_L = 30'h1234_5678;
    localparam logic [3:0]  RD_S_EXP = (C == 1) ? PAR_S : 4'b0000;
    localparam logic [29:0] RD_L_EXP = (C == 1) ? PAR_L : 30'h0;

    logic        ref_clk = 1'b0;
    logic        reset_bar;
    logic        start_s, start_l;
    logic [3:0]  wd_s;
    logic [29:0] wd_l;

    logic        busy_s, done_s, scan_in_s, phi_s, phi_bar_s, capture_s, update_s;
    logic [3:0]  read_data_s;
    logic        busy_l, done_l, scan_in_l, phi_l, phi_bar_l, capture_l, update_l;
    logic [29:0] read_data_l;

    // Chain models
    logic [3:0]  master_s = '0, slave_s = '0, upd_s = '0;
    logic [29:0] master_l = '0, slave_l = '0, upd_l = '0;

    always #5 ref_clk = ~ref_clk;

    scan_master #(.REGISTER_LENGTH(4), .HALF_CYCLES(1)) dut_s (
        .ref_clk    (ref_clk),
        .reset_bar  (reset_bar),
        .start      (start_s),
        .write_data (wd_s),
        .busy       (busy_s),
        .done       (done_s),
        .read_data  (read_data_s),
        .scan_in    (scan_in_s),
        .phi        (phi_s),
        .phi_bar    (phi_bar_s),
        .capture    (capture_s),
        .update     (update_s),
        .scan_out   (slave_s[3])
    );

    scan_master dut_l (
        .ref_clk    (ref_clk),
        .reset_bar  (reset_bar),
        .start      (start_l),
        .write_data (wd_l),
        .busy       (busy_l),
        .done       (done_l),
        .read_data  (read_data_l),
        .scan_in    (scan_in_l),
        .phi        (phi_l),
        .phi_bar    (phi_bar_l),
        .capture    (capture_l),
        .update     (update_l),
        .scan_out   (slave_l[29])
    );

    // Chip chain: phi loads masters (parallel when capturing), phi_bar moves to slaves.
    always @(negedge ref_clk) begin
        if (phi_s)     master_s <= capture_s ? PAR_S : {slave_s[2:0], scan_in_s};
        if (phi_bar_s) slave_s  <= master_s;
        if (update_s)  upd_s    <= slave_s;
        if (phi_l)     master_l <= capture_l ? PAR_L : {slave_l[28:0], scan_in_l};
        if (phi_bar_l) slave_l  <= master_l;
        if (update_l)  upd_l    <= slave_l;
    end

    // Protocol monitors: phase overlap, scan_in moving outside S0, strobe counts.
    int   overlap_cnt = 0, sin_bad_cnt = 0, upd_hi_s = 0, done_hi_s = 0;
    logic prev_rst = 1'b0;
    logic p_sin_s = 1'b0, p_phib_s = 1'b0, p_busy_s = 1'b0;
    logic p_sin_l = 1'b0, p_phib_l = 1'b0, p_busy_l = 1'b0;

    always @(negedge ref_clk) begin
        if (reset_bar && prev_rst) begin
            if (phi_s && phi_bar_s) overlap_cnt++;
            if (phi_l && phi_bar_l) overlap_cnt++;
            if (scan_in_s !== p_sin_s &&
                !(busy_s && !phi_s && !phi_bar_s && (p_phib_s || !p_busy_s)))
                sin_bad_cnt++;
            if (scan_in_l !== p_sin_l &&
                !(busy_l && !phi_l && !phi_bar_l && (p_phib_l || !p_busy_l)))
                sin_bad_cnt++;
            if (update_s) upd_hi_s++;
            if (done_s)   done_hi_s++;
        end
        prev_rst = reset_bar;
        p_sin_s  = scan_in_s; p_phib_s = phi_bar_s; p_busy_s = busy_s;
        p_sin_l  = scan_in_l; p_phib_l = phi_bar_l; p_busy_l = busy_l;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction on the selected DUT, observed at negedges.
    // t_done = done cycle minus first busy cycle (-1 if done never seen).
    task automatic do_txn(input bit big, input logic [29:0] wd, input bit immediate,
                          input bit repulse, input int extra,
                          output int t_done, output int n_busy, output int n_done,
                          output int n_phi, output int n_cap, output int n_upd);
        int   cyc;
        logic b, dn, ph, cp, up;
        t_done = -1; n_busy = 0; n_done = 0; n_phi = 0; n_cap = 0; n_upd = 0;
        if (!immediate) @(negedge ref_clk);
        if (big) begin start_l = 1'b1; wd_l = wd; end
        else     begin start_s = 1'b1; wd_s = wd[3:0]; end
        @(negedge ref_clk);
        start_s = 1'b0; start_l = 1'b0;
        wd_s = ~wd_s;   wd_l = ~wd_l;
        cyc = 1;
        while (cyc < 400) begin
            b  = big ? busy_l    : busy_s;
            dn = big ? done_l    : done_s;
            ph = big ? phi_l     : phi_s;
            cp = big ? capture_l : capture_s;
            up = big ? update_l  : update_s;
            if (b)  n_busy++;
            if (ph) n_phi++;
            if (cp) n_cap++;
            if (up) n_upd++;
            if (repulse && (cyc == 5 || cyc == 10)) begin
                if (big) start_l = 1'b1; else start_s = 1'b1;
            end
            if (dn) begin
                n_done++;
                if (t_done < 0) t_done = cyc - 1;
                if (repulse) begin
                    if (big) start_l = 1'b1; else start_s = 1'b1;
                end
            end
            if (t_done >= 0 && cyc >= t_done + 1 + extra) break;
            cyc++;
            @(negedge ref_clk);
            start_s = 1'b0; start_l = 1'b0;
        end
    endtask

    initial begin
        int t, nb, nd, np, nc, nu;
        int u0, d0;

        reset_bar = 1'b0;
        start_s = 1'b0; start_l = 1'b0;
        wd_s = '0; wd_l = '0;
        repeat (3) @(negedge ref_clk);
        check("reset_small", {busy_s, done_s, scan_in_s, phi_s, phi_bar_s, capture_s,
                              update_s, read_data_s}, 64'h0);
        check("reset_large", {busy_l, done_l, scan_in_l, phi_l, phi_bar_l, capture_l,
                              update_l, read_data_l}, 64'h0);

        // Release and start in the same cycle: first cycle must accept.
        reset_bar = 1'b1;
        do_txn(1'b0, 30'b1010, 1'b1, 1'b0, 0, t, nb, nd, np, nc, nu);
        check("t1_length",  64'(t),  64'(T_S));
        check("t1_busy",    64'(nb), 64'(T_S));
        check("t1_done",    64'(nd), 64'd1);
        check("t1_phi",     64'(np), 64'(4 + C));
        check("t1_capture", 64'(nc), 64'(C * 4));
        check("t1_update",  64'(nu), 64'd1);
        check("t1_rdata",   64'(read_data_s), 64'(RD_S_EXP));
        check("t1_latch",   64'(upd_s), 64'b1010);

        // Back-to-back: second start lands in the IDLE cycle after DONE.
        do_txn(1'b0, 30'b0011, 1'b0, 1'b0, 0, t, nb, nd, np, nc, nu);
        check("b2b_a_length", 64'(t), 64'(T_S));
        check("b2b_a_latch",  64'(upd_s), 64'b0011);
        check("b2b_a_rdata",  64'(read_data_s), 64'(RD_S_EXP));
        do_txn(1'b0, 30'b1100, 1'b0, 1'b0, 0, t, nb, nd, np, nc, nu);
        check("b2b_b_length", 64'(t), 64'(T_S));
        check("b2b_b_busy",   64'(nb), 64'(T_S));
        check("b2b_b_latch",  64'(upd_s), 64'b1100);

        // Extra starts at cycles 5, 10 and in DONE must be ignored.
        do_txn(1'b0, 30'b0101, 1'b0, 1'b1, 10, t, nb, nd, np, nc, nu);
        check("ign_length", 64'(t),  64'(T_S));
        check("ign_busy",   64'(nb), 64'(T_S));
        check("ign_done",   64'(nd), 64'd1);
        check("ign_latch",  64'(upd_s), 64'b0101);

        // Default parameters.
        do_txn(1'b1, 30'h2D4C_3A71, 1'b0, 1'b0, 0, t, nb, nd, np, nc, nu);
        check("big_length",  64'(t),  64'(T_L));
        check("big_busy",    64'(nb), 64'(T_L));
        check("big_phi",     64'(np), 64'((30 + C) * 2));
        check("big_capture", 64'(nc), 64'(C * 6));
        check("big_update",  64'(nu), 64'd2);
        check("big_latch",   64'(upd_l), 64'(30'h2D4C_3A71));
        check("big_rdata",   64'(read_data_l), 64'(RD_L_EXP));
        check("phase_overlap",   64'(overlap_cnt), 64'd0);
        check("scan_in_outside", 64'(sin_bad_cnt), 64'd0);

        // Abort during bit 2 of SHIFT.
        @(negedge ref_clk);
        start_s = 1'b1; wd_s = 4'b1001;
        @(negedge ref_clk);
        start_s = 1'b0;
        u0 = upd_hi_s; d0 = done_hi_s;
        repeat (C * 4 + 9) @(negedge ref_clk);
        check("abort_in_bit2_phi", 64'(phi_s), 64'd1);
        #2 reset_bar = 1'b0;
        #1 check("abort_outputs", {busy_s, done_s, scan_in_s, phi_s, phi_bar_s, capture_s,
                                   update_s, read_data_s}, 64'h0);
        repeat (3) @(negedge ref_clk);
        check("abort_no_update", 64'(upd_hi_s - u0), 64'd0);
        check("abort_no_done",   64'(done_hi_s - d0), 64'd0);
        check("abort_latch",     64'(upd_s), 64'b0101);
        reset_bar = 1'b1;
        do_txn(1'b0, 30'b1001, 1'b1, 1'b0, 0, t, nb, nd, np, nc, nu);
        check("post_abort_length", 64'(t),  64'(T_S));
        check("post_abort_done",   64'(nd), 64'd1);
        check("post_abort_latch",  64'(upd_s), 64'b1001);
        check("post_abort_rdata",  64'(read_data_s), 64'(RD_S_EXP));

        repeat (2) @(negedge ref_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
